// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small show-ahead FIFO of received bytes.
// Sticky overrun/framing flags; synchronous active-high reset.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  input  logic       i_RD_En,
  input  logic       i_Clr_Err,
  output logic [7:0] o_RX_Byte,
  output logic       o_Empty,
  output logic       o_Full,
  output logic       o_Overrun,
  output logic       o_Frame_Err,
  output logic       o_RX_Active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [PTR_W:0]   FULL_CNT = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic             push;
  logic             pop;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [7:0]       mem [FIFO_DEPTH];

  // A good stop bit is seen on the last clock of the stop bit period.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    push = 1'b0;
    if (state == STOP && cnt == CNT_LAST && rx_s) push = 1'b1;
  end

  assign o_Empty = (count == '0);
  assign o_Full  = (count == FULL_CNT);
  assign pop     = i_RD_En && !o_Empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign wr_en   = push && (!o_Full || pop) && !i_Rst;
  assign o_RX_Byte = o_Empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_Rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Frame_Err <= 1'b0;
      o_RX_Active <= 1'b0;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
      if (i_Clr_Err) o_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state       <= START;
            o_RX_Active <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state       <= IDLE;
              o_RX_Active <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state       <= IDLE;
              o_RX_Active <= 1'b0;
            end else begin
              state       <= BREAK_WAIT;
              o_Frame_Err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK_WAIT: begin
          cnt <= '0;
          if (rx_s) begin
            state       <= IDLE;
            o_RX_Active <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          o_RX_Active <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the byte storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_Overrun <= 1'b0;
    end else begin
      if (i_Clr_Err) o_Overrun <= 1'b0;
      if (push && o_Full && !pop) o_Overrun <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks/bit and a 4-entry FIFO.
// A vector table drives frame/pop/clear operations; corner cases are scripted.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_byte;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       frame_err;
  logic       rx_active;

  int checks = 0;
  int passed = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_Clock     (clk),
    .i_Rst       (rst),
    .i_RX_Serial (rx),
    .i_RD_En     (rd_en),
    .i_Clr_Err   (clr_err),
    .o_RX_Byte   (rx_byte),
    .o_Empty     (empty),
    .o_Full      (full),
    .o_Overrun   (overrun),
    .o_Frame_Err (frame_err),
    .o_RX_Active (rx_active)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_FRAME, OP_POP, OP_CLR} op_t;

  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic       rd_at_stop;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_byte;
    logic       exp_ovr;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input op_t op, input logic [7:0] data, input logic rds,
                     input logic e, input logic f, input logic [7:0] b,
                     input logic o, input logic fe);
    vec_t v;
    v.op = op; v.data = data; v.rd_at_stop = rds;
    v.exp_empty = e; v.exp_full = f; v.exp_byte = b; v.exp_ovr = o; v.exp_fe = fe;
    vecs.push_back(v);
  endtask

  // Drives one full frame starting at the current negedge; returns at the
  // negedge that ends the stop bit with the line left at the stop value.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic rd_at_stop);
    for (int i = 0; i < 10 * CPB; i++) begin
      int b;
      b = i / CPB;
      if (b == 0)      rx = 1'b0;
      else if (b == 9) rx = stop;
      else             rx = data[b-1];
      rd_en = rd_at_stop && (i == 10 * CPB - 6);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic e, input logic f, input logic [7:0] b,
                           input logic o, input logic fe, input logic act);
    check({tag, ".empty"},     {7'd0, empty},     {7'd0, e});
    check({tag, ".full"},      {7'd0, full},      {7'd0, f});
    check({tag, ".byte"},      rx_byte,           b);
    check({tag, ".overrun"},   {7'd0, overrun},   {7'd0, o});
    check({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, fe});
    check({tag, ".active"},    {7'd0, rx_active}, {7'd0, act});
  endtask

  initial begin
    bit done;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    add(OP_FRAME, 8'h3F, 1'b0, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(OP_FRAME, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    add(OP_FRAME, 8'h02, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    add(OP_FRAME, 8'h03, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    add(OP_FRAME, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    add(OP_FRAME, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    add(OP_CLR,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(OP_FRAME, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
    add(OP_FRAME, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
    add(OP_FRAME, 8'h33, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
    add(OP_FRAME, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    add(OP_FRAME, 8'h55, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(OP_FRAME, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_FRAME: send_frame(vecs[i].data, 1'b1, vecs[i].rd_at_stop);
        OP_POP: begin
          rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        end
        default: begin
          clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        end
      endcase
      check_all($sformatf("vec%0d", i), vecs[i].exp_empty, vecs[i].exp_full,
                vecs[i].exp_byte, vecs[i].exp_ovr, vecs[i].exp_fe, 1'b0);
    end

    // Start-bit glitch: 5 low clocks must be rejected without a push.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch.active_high", {7'd0, rx_active}, 8'h01);
    rx = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (!rx_active) done = 1'b1;
    end
    check("glitch.idle_within_8", {7'd0, done}, 8'h01);
    repeat (20) @(negedge clk);
    check_all("glitch.after", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Framing error followed by a 40-bit break: exactly one error event.
    send_frame(8'hA5, 1'b0, 1'b0);
    check_all("ferr.flag", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    repeat (5 * CPB) @(negedge clk);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("ferr.cleared", {7'd0, frame_err}, 8'h00);
    repeat (35 * CPB) @(negedge clk);
    check("ferr.no_repeat", {7'd0, frame_err}, 8'h00);
    check("ferr.break_active", {7'd0, rx_active}, 8'h01);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_all("ferr.end", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset during DATA of 0x55 drops the partial byte and the FIFO contents.
    send_frame(8'h3C, 1'b1, 1'b0);
    check("rst.pre_byte", rx_byte, 8'h3C);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    check("rst.mid_active", {7'd0, rx_active}, 8'h01);
    rst = 1'b1; rx = 1'b1; rd_en = 1'b1; clr_err = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check_all("rst.release", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (12 * CPB) @(negedge clk);
    check_all("rst.idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
